// File: rtl/txt_pkg.sv
// txt_pkg: shared geometry, latency and pipeline types for text_renderer
package txt_pkg;
  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 60;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;
  localparam int PIPE_LAT = 4;
  localparam int ADDR_W = 13;
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;
  typedef struct packed {
    logic       ok;
    logic       hit;
    logic [2:0] x;
  } pix_ctl_t;
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] col, input logic [6:0] row, input int cols);
    return ADDR_W'(int'(row) * cols + int'(col));
  endfunction
endpackage

// File: rtl/text_renderer_if.sv
// text_renderer_if: text RAM and glyph ROM port bundle of text_renderer
interface text_renderer_if;
  import txt_pkg::*;
  logic [ADDR_W-1:0] txt_addr;
  logic [7:0]        txt_data;
  logic [9:0]        rom_ad;
  logic              rom_ce;
  logic [7:0]        rom_dout;
  modport master(output txt_addr, rom_ad, rom_ce, input txt_data, rom_dout);
  modport slave(input txt_addr, rom_ad, rom_ce, output txt_data, rom_dout);
endinterface

// File: rtl/pipe_delay.sv
// pipe_delay: D-stage shift register of width W, cleared to RST_VAL on reset
module pipe_delay #(
  parameter int W = 1,
  parameter int D = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [D];
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < D; i++) sr[i] <= RST_VAL;
    else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[D-1];
endmodule

// File: rtl/text_renderer.sv
// text_renderer: 8x8 character-cell text renderer with a fixed 4-cycle pipeline.
// Optional blinking underline cursor is built when TXT_CURSOR_EN is defined.
module text_renderer
  import txt_pkg::*;
#(
  parameter int   COLS      = COLS_DEF,
  parameter int   ROWS      = ROWS_DEF,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             x_i,
  input  logic [9:0]             y_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  text_renderer_if.master        mem,
`ifdef TXT_CURSOR_EN
  input  logic [6:0]             cur_col,
  input  logic [5:0]             cur_row,
`endif
  output logic                   pix_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
);
  localparam sync_t IDLE = '{de: 1'b0, hs: SYNC_IDLE, vs: SYNC_IDLE};
  localparam int LW = $clog2(GLYPH_H);
  logic                in_range;
  logic                hit;
  logic                inv;
  sync_t               sync_in;
  sync_t               sync_d;
  logic [LW-1:0]       y2;
  pix_ctl_t            ctl_in;
  pix_ctl_t            ctl3;
  logic [GLYPH_W-1:0]  glyph;
  assign in_range = 32'(x_i[9:3]) < COLS && 32'(y_i[9:3]) < ROWS;
`ifdef TXT_CURSOR_EN
  logic [4:0] frame;
  logic       vs_q;
  always_ff @(posedge clk)
    if (reset) begin
      frame <= '0;
      vs_q  <= SYNC_IDLE;
    end else begin
      frame <= frame + 5'(vs_q == SYNC_IDLE && vs_i != SYNC_IDLE);
      vs_q  <= vs_i;
    end
  // underline on the last glyph line, visible during the first half of each 32-frame period
  assign hit = x_i[9:3] == cur_col && y_i[9:3] == {1'b0, cur_row} && &y_i[2:0] && !frame[4];
`else
  assign hit = 1'b0;
`endif
  assign sync_in = '{de: de_i, hs: hs_i, vs: vs_i};
  assign ctl_in  = '{ok: de_i & in_range, hit: hit, x: x_i[2:0]};
  pipe_delay #(.W($bits(sync_t)), .D(PIPE_LAT), .RST_VAL(IDLE)) u_sync (
    .clk(clk), .reset(reset), .d(sync_in), .q(sync_d)
  );
  pipe_delay #(.W(LW), .D(2), .RST_VAL('0)) u_line (
    .clk(clk), .reset(reset), .d(y_i[LW-1:0]), .q(y2)
  );
  pipe_delay #(.W($bits(pix_ctl_t)), .D(PIPE_LAT-1), .RST_VAL('0)) u_ctl (
    .clk(clk), .reset(reset), .d(ctl_in), .q(ctl3)
  );
  assign mem.rom_ad = {mem.txt_data[6:0], y2};
  assign mem.rom_ce = !reset;
  assign glyph      = ctl3.hit ? '1 : mem.rom_dout ^ {GLYPH_W{inv}};
  assign {de_o, hs_o, vs_o} = sync_d;
  always_ff @(posedge clk) begin
    mem.txt_addr <= reset || !in_range ? '0 : cell_addr(x_i[9:3], y_i[9:3], COLS);
    inv          <= !reset && mem.txt_data[7];
    pix_o        <= !reset && ctl3.ok && glyph[~ctl3.x];
  end
endmodule

// File: tb/tb_text_renderer.sv
// tb_text_renderer: table vectors, directed latency/reset/cursor sequences and a random stream
// checked against an array-based text/glyph model of text_renderer.
module tb_text_renderer;
  import txt_pkg::*;
  localparam int   COLS = 80;
  localparam int   ROWS = 60;
  localparam logic SI   = 1'b1;
  typedef struct { int x; int y; logic de; logic hs; logic vs; int addr; logic pix; } vec_t;
  typedef struct { logic pix; logic de; logic hs; logic vs; } exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [9:0] x_i = '0, y_i = '0;
  logic de_i = 1'b0, hs_i = SI, vs_i = SI;
  logic pix_o, de_o, hs_o, vs_o;
`ifdef TXT_CURSOR_EN
  logic [6:0] cur_col = 7'd100;
  logic [5:0] cur_row = 6'd0;
`endif
  logic [7:0] ram [0:8191];
  logic [7:0] rom [0:1023];
  int   n_cmp = 0, n_bad = 0, cnt = 0;
  logic pvs = SI;
  exp_t q[$];
  vec_t tbl[$];
  logic [7:0] pa = 8'b0011_0000, pb = 8'b1100_1111;
  text_renderer_if mem();
  text_renderer #(.COLS(COLS), .ROWS(ROWS), .SYNC_IDLE(SI)) dut (
    .clk(clk), .reset(reset), .x_i(x_i), .y_i(y_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .mem(mem),
`ifdef TXT_CURSOR_EN
    .cur_col(cur_col), .cur_row(cur_row),
`endif
    .pix_o(pix_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    mem.txt_data <= ram[mem.txt_addr];
    if (mem.rom_ce) mem.rom_dout <= rom[mem.rom_ad];
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(int x, int y, logic de, logic hs, logic vs);
    x_i = 10'(x);
    y_i = 10'(y);
    de_i = de;
    hs_i = hs;
    vs_i = vs;
  endtask
  function automatic int model_addr(int x, int y);
    return (x / 8 < COLS && y / 8 < ROWS) ? (y / 8) * COLS + x / 8 : 0;
  endfunction
  function automatic logic model_pix(int x, int y, logic de);
    int col, row;
    logic [7:0] ch, g;
    col = x / 8;
    row = y / 8;
    if (!de || col >= COLS || row >= ROWS) return 1'b0;
    ch = ram[row * COLS + col];
    g = rom[(ch % 128) * 8 + y % 8];
    if (ch >= 128) g = ~g;
`ifdef TXT_CURSOR_EN
    if (col == cur_col && row == cur_row && y % 8 == 7 && cnt < 16) g = 8'hFF;
`endif
    return g[7 - x % 8];
  endfunction
  task automatic step(int x, int y, logic de, logic hs, logic vs, int addr, logic pix);
    exp_t e;
    drive(x, y, de, hs, vs);
    q.push_back('{pix, de, hs, vs});
    if (pvs == SI && vs != SI) cnt = (cnt + 1) % 32;
    pvs = vs;
    tick;
    chk("txt_addr", mem.txt_addr, addr);
    if (q.size() == PIPE_LAT) begin
      e = q.pop_front();
      chk("pix_o", pix_o, e.pix);
      chk("de_o", de_o, e.de);
      chk("hs_o", hs_o, e.hs);
      chk("vs_o", vs_o, e.vs);
    end
  endtask
  task automatic idle(int n);
    repeat (n) step(0, 0, 1'b0, SI, SI, 0, 1'b0);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    drive(0, 0, 1'b0, SI, SI);
    tick;
    tick;
    reset = 1'b0;
    q.delete();
    cnt = 0;
    pvs = SI;
  endtask
  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    ram[0] = 8'h41; rom[10'h208] = 8'h30;
    ram[1] = 8'hC1;
    ram[2] = 8'h42; rom[10'h210] = 8'hFF;
    ram[79] = 8'h43; rom[10'h218] = 8'h01;
    ram[4720] = 8'h44; rom[10'h227] = 8'h80;
    // reset state
    drive(5, 0, 1'b1, 1'b0, 1'b0);
    tick;
    tick;
    chk("rst_pix", pix_o, 0);
    chk("rst_de", de_o, 0);
    chk("rst_hs", hs_o, SI);
    chk("rst_vs", vs_o, SI);
    chk("rst_addr", mem.txt_addr, 0);
    chk("rst_ce", mem.rom_ce, 0);
    do_reset;
    // latency: pulse at cycle 10 emerges 4 cycles later
    drive(0, 0, 1'b0, SI, SI);
    repeat (9) tick;
    drive(16, 8, 1'b1, 1'b0, SI);
    tick;
    chk("lat_addr", mem.txt_addr, 82);
    chk("lat_ce", mem.rom_ce, 1);
    drive(0, 0, 1'b0, SI, SI);
    tick;
    chk("lat_de_e1", de_o, 0);
    tick;
    chk("lat_de_e2", de_o, 0);
    tick;
    chk("lat_de_e3", de_o, 1);
    chk("lat_hs_e3", hs_o, 0);
    tick;
    chk("lat_de_e4", de_o, 0);
    chk("lat_hs_e4", hs_o, SI);
    drive(0, 0, 1'b1, SI, SI);
    tick;
    tick;
    chk("rom_ad", mem.rom_ad, 10'h208);
    drive(0, 0, 1'b0, SI, SI);
    repeat (4) tick;
    // table-driven vectors
    for (int i = 0; i < 8; i++) tbl.push_back('{i, 0, 1'b1, SI, SI, 0, pa[7-i]});
    for (int i = 0; i < 8; i++) tbl.push_back('{8 + i, 0, 1'b1, SI, SI, 1, pb[7-i]});
    tbl.push_back('{16, 8, 1'b1, 1'b0, SI, 82, 1'b0});
    tbl.push_back('{16, 0, 1'b0, SI, SI, 2, 1'b0});
    tbl.push_back('{17, 0, 1'b1, SI, SI, 2, 1'b1});
    tbl.push_back('{639, 0, 1'b1, SI, 1'b0, 79, 1'b1});
    tbl.push_back('{0, 479, 1'b1, SI, SI, 4720, 1'b1});
    tbl.push_back('{642, 0, 1'b1, SI, SI, 0, 1'b0});
    tbl.push_back('{2, 480, 1'b1, SI, SI, 0, 1'b0});
    tbl.push_back('{1023, 1023, 1'b1, SI, SI, 0, 1'b0});
    q.delete();
    foreach (tbl[i]) step(tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].addr, tbl[i].pix);
    idle(4);
    // reset mid-line, then clean restart on the inverse-video cell
    for (int i = 0; i < 6; i++) begin
      drive(i, 0, 1'b1, SI, SI);
      tick;
    end
    reset = 1'b1;
    drive(2, 0, 1'b1, SI, 1'b0);
    tick;
    chk("mid_pix", pix_o, 0);
    chk("mid_vs", vs_o, SI);
    chk("mid_ce", mem.rom_ce, 0);
    chk("mid_de", de_o, 0);
    chk("mid_addr", mem.txt_addr, 0);
    tick;
    reset = 1'b0;
    for (int k = 0; k < 11; k++) begin
      drive(k < 8 ? 8 + k : 0, 0, k < 8, SI, SI);
      tick;
      if (k < 3) begin
        chk("mid_stale_pix", pix_o, 0);
        chk("mid_stale_de", de_o, 0);
      end else begin
        chk("mid_pix_after", pix_o, pb[7-(k-3)]);
        chk("mid_de_after", de_o, 1);
      end
    end
    // randomized stream against the model
`ifdef TXT_CURSOR_EN
    cur_col = 7'($urandom_range(0, 79));
    cur_row = 6'($urandom_range(0, 59));
`endif
    do_reset;
    for (int i = 0; i < 8192; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      int x, y;
      logic de, hs, vs;
      x = $urandom_range(0, 700);
      y = $urandom_range(0, 500);
`ifdef TXT_CURSOR_EN
      if ($urandom_range(0, 3) == 0) begin
        x = cur_col * 8 + $urandom_range(0, 7);
        y = cur_row * 8 + 7;
      end
`endif
      de = $urandom_range(0, 3) != 0;
      hs = 1'($urandom_range(0, 1));
      vs = $urandom_range(0, 19) != 0;
      step(x, y, de, hs, vs, model_addr(x, y), model_pix(x, y, de));
    end
    idle(4);
`ifdef TXT_CURSOR_EN
    // cursor blink over 33 frames
    cur_col = 7'd2;
    cur_row = 6'd1;
    ram[82] = 8'h00;
    rom[7] = 8'h00;
    do_reset;
    for (int f = 0; f <= 32; f++) begin
      if (f > 0) begin
        step(0, 0, 1'b0, SI, !SI, 0, 1'b0);
        step(0, 0, 1'b0, SI, SI, 0, 1'b0);
      end
      for (int x = 16; x < 24; x++) step(x, 15, 1'b1, SI, SI, 82, f < 16 || f == 32);
    end
    idle(4);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
